// File: rtl/return_address_stack.sv
// Return-address stack feeding the RA operand of the instruction address generator.
// Circular storage: a push while full silently replaces the oldest entry.
module return_address_stack #(
   parameter int DEPTH      = 8,
   parameter int AW         = 32,
   parameter int RET_OFFSET = 1,
   localparam int PW        = $clog2(DEPTH),
   localparam int CW        = PW + 1
) (
   input  logic          Clock,
   input  logic          Reset_n,
   input  logic          Push,
   input  logic          Pop,
   input  logic          Clear,
   input  logic [AW-1:0] PushAddr,
   output logic [AW-1:0] RA,
   output logic [CW-1:0] Count,
   output logic          Empty,
   output logic          Full,
   output logic          Overflow,
   output logic          Underflow
);

   logic [AW-1:0] mem_q [DEPTH];
   logic [PW-1:0] top_q, top_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic          mem_we_s;
   logic [PW-1:0] mem_waddr_s;
   logic [AW-1:0] push_val_s;
   logic [PW-1:0] rd_idx_s;
   logic          empty_s;
   logic          full_s;

   assign push_val_s = PushAddr + AW'(RET_OFFSET);
   assign empty_s    = (count_q == {CW{1'b0}});
   assign full_s     = (count_q == CW'(DEPTH));
   assign rd_idx_s   = top_q - PW'(1);

   // Next-state decode in priority order: Clear, Push&Pop, Push, Pop, idle.
   always_comb begin
      top_d       = top_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      mem_we_s    = 1'b0;
      mem_waddr_s = top_q;
      if (Clear) begin
         top_d   = {PW{1'b0}};
         count_d = {CW{1'b0}};
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (Push && Pop) begin
         mem_we_s = 1'b1;
         if (!empty_s) begin
            // Return immediately followed by a call: replace top in place.
            mem_waddr_s = rd_idx_s;
         end else begin
            mem_waddr_s = top_q;
            top_d       = top_q + PW'(1);
            count_d     = CW'(1);
         end
      end else if (Push) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = top_q;
         top_d       = top_q + PW'(1);
         if (full_s) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (Pop) begin
         if (empty_s) begin
            unf_d = 1'b1;
         end else begin
            top_d   = rd_idx_s;
            count_d = count_q - CW'(1);
         end
      end else begin
         top_d = top_q;
      end
   end

   // Control state: pointer, occupancy and sticky error flags.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         top_q   <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage array; contents are meaningless while Count says the slot is free.
   always_ff @(posedge Clock) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= push_val_s;
      end
   end

   assign RA        = empty_s ? {AW{1'b0}} : mem_q[rd_idx_s];
   assign Count     = count_q;
   assign Empty     = empty_s;
   assign Full      = full_s;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: queue-based reference model
// compared every falling edge, plus directed literal expectations.
module tb_return_address_stack;

   localparam int DEPTH = 8;
   localparam int AW    = 32;

   logic          Clock;
   logic          Reset_n;
   logic          Push;
   logic          Pop;
   logic          Clear;
   logic [AW-1:0] PushAddr;
   logic [AW-1:0] RA;
   logic [3:0]    Count;
   logic          Empty;
   logic          Full;
   logic          Overflow;
   logic          Underflow;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: youngest entry at the back of the queue.
   logic [AW-1:0] mq [$];
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;

   return_address_stack #(.DEPTH(DEPTH), .AW(AW), .RET_OFFSET(1)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .Push      (Push),
      .Pop       (Pop),
      .Clear     (Clear),
      .PushAddr  (PushAddr),
      .RA        (RA),
      .Count     (Count),
      .Empty     (Empty),
      .Full      (Full),
      .Overflow  (Overflow),
      .Underflow (Underflow)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] m_ra();
      if (mq.size() == 0) return '0;
      return mq[mq.size()-1];
   endfunction

   task automatic model_clear();
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_edge(input logic pu, input logic po, input logic cl, input logic [AW-1:0] a);
      logic [AW-1:0] v;
      v = a + 32'd1;
      if (!Reset_n || cl) begin
         model_clear();
      end else if (pu && po) begin
         if (mq.size() > 0) mq[mq.size()-1] = v;
         else mq.push_back(v);
      end else if (pu) begin
         if (mq.size() == DEPTH) begin
            void'(mq.pop_front());
            m_ovf = 1'b1;
         end
         mq.push_back(v);
      end else if (po) begin
         if (mq.size() == 0) m_unf = 1'b1;
         else void'(mq.pop_back());
      end
   endtask

   task automatic step(input logic pu, input logic po, input logic cl, input logic [AW-1:0] a);
      Push = pu; Pop = po; Clear = cl; PushAddr = a;
      @(posedge Clock);
      model_edge(pu, po, cl, a);
      #1;
      Push = 1'b0; Pop = 1'b0; Clear = 1'b0; PushAddr = '0;
   endtask

   // Model-vs-DUT comparison on every falling edge.
   always @(negedge Clock) begin
      chk("m_ra",   RA,                   m_ra());
      chk("m_cnt",  32'(Count),           32'(mq.size()));
      chk("m_emp",  32'(Empty),           32'(mq.size() == 0));
      chk("m_full", 32'(Full),            32'(mq.size() == DEPTH));
      chk("m_ovf",  32'(Overflow),        32'(m_ovf));
      chk("m_unf",  32'(Underflow),       32'(m_unf));
   end

   initial begin
      Reset_n = 1'b0; Push = 1'b0; Pop = 1'b0; Clear = 1'b0; PushAddr = '0;
      model_clear();
      #12;
      chk("rst_ra",    RA,           32'h0);
      chk("rst_cnt",   32'(Count),   32'd0);
      chk("rst_empty", 32'(Empty),   32'd1);
      chk("rst_full",  32'(Full),    32'd0);
      Reset_n = 1'b1;

      // Three nested calls
      step(1'b1, 1'b0, 1'b0, 32'h10); chk("t1_ra0", RA, 32'h11);
      step(1'b1, 1'b0, 1'b0, 32'h20); chk("t1_ra1", RA, 32'h21);
      step(1'b1, 1'b0, 1'b0, 32'h30); chk("t1_ra2", RA, 32'h31);
      chk("t1_cnt", 32'(Count), 32'd3);
      chk("t1_empty", 32'(Empty), 32'd0);

      // Unwind
      step(1'b0, 1'b1, 1'b0, 32'h0); chk("t2_ra0", RA, 32'h21);
      step(1'b0, 1'b1, 1'b0, 32'h0); chk("t2_ra1", RA, 32'h11);
      step(1'b0, 1'b1, 1'b0, 32'h0); chk("t2_ra2", RA, 32'h0);
      chk("t2_cnt", 32'(Count), 32'd0);
      chk("t2_empty", 32'(Empty), 32'd1);
      chk("t2_unf", 32'(Underflow), 32'd0);

      // Underflow is sticky across a later push
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("t3_unf", 32'(Underflow), 32'd1);
      chk("t3_cnt", 32'(Count), 32'd0);
      chk("t3_ra", RA, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h40);
      chk("t3_ra2", RA, 32'h41);
      chk("t3_unf2", 32'(Underflow), 32'd1);
      step(1'b0, 1'b0, 1'b1, 32'h0);
      chk("t3_clr_unf", 32'(Underflow), 32'd0);

      // Overflow: 9 pushes into 8 slots, oldest entry lost
      for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, 32'(i));
      chk("t4_full", 32'(Full), 32'd1);
      chk("t4_ovf", 32'(Overflow), 32'd1);
      chk("t4_cnt", 32'(Count), 32'd8);
      chk("t4_ra", RA, 32'hA);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         chk("t4_pop_ra", RA, (k < 8) ? 32'(10 - k) : 32'h0);
      end
      chk("t4_ovf_sticky", 32'(Overflow), 32'd1);
      step(1'b0, 1'b0, 1'b1, 32'h0);

      // Simultaneous push and pop
      step(1'b1, 1'b0, 1'b0, 32'h50);
      step(1'b1, 1'b1, 1'b0, 32'h60);
      chk("t5_cnt", 32'(Count), 32'd1);
      chk("t5_ra", RA, 32'h61);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h70);
      chk("t5_cnt2", 32'(Count), 32'd1);
      chk("t5_ra2", RA, 32'h71);
      chk("t5_unf", 32'(Underflow), 32'd0);

      // Wrap-around pointer exercise with mixed operations (model-checked)
      for (int i = 0; i < 20; i++) begin
         step(1'b1, (i % 3) == 2, 1'b0, 32'h1000 + 32'(i * 4));
         if ((i % 5) == 4) step(1'b0, 1'b1, 1'b0, 32'h0);
      end
      chk("t5_addr_wrap_ra", m_ra(), RA);
      step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
      chk("t5_trunc", RA, 32'h0);

      // Clear overrides Push, flags cleared
      step(1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'hA0);
      step(1'b1, 1'b0, 1'b0, 32'hB0);
      step(1'b1, 1'b0, 1'b1, 32'hC0);
      chk("t6_clr_cnt", 32'(Count), 32'd0);
      chk("t6_clr_ra", RA, 32'h0);
      chk("t6_clr_unf", 32'(Underflow), 32'd0);

      // Asynchronous reset between edges
      step(1'b1, 1'b0, 1'b0, 32'hD0);
      step(1'b1, 1'b0, 1'b0, 32'hE0);
      #2;
      Reset_n = 1'b0;
      model_clear();
      #1;
      chk("t6_rst_cnt", 32'(Count), 32'd0);
      chk("t6_rst_ra", RA, 32'h0);
      chk("t6_rst_empty", 32'(Empty), 32'd1);
      chk("t6_rst_ovf", 32'(Overflow), 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'hF0);
      chk("t6_rst_hold", 32'(Count), 32'd0);
      #3;
      Reset_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h300);
      chk("t6_post_ra", RA, 32'h301);
      chk("t6_post_cnt", 32'(Count), 32'd1);

      @(negedge Clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
Hardware return-address stack that produces the RA operand for the instruction address generator. It sits between the PC_temp output (push side) and the RA input (pop side, PC_select = 0). On a call it captures the return address. On a return it supplies the address to jump back to. Nested calls are supported up to DEPTH levels, with circular overwrite of the oldest entry on overflow.

Parameters:
DEPTH, 8, number of stack entries (power of two, ≥2)
AW, 32, address width (matches PC/RA width)
RET_OFFSET, 1, value added to PushAddr before storing (return lands after the call)

Ports:
Clock  input  1  rising-edge clock shared with the datapath
Reset_n  input  1  asynchronous, active-low reset
Push  input  1  call retiring this cycle; store PushAddr+RET_OFFSET
Pop  input  1  return retiring this cycle; discard top entry
Clear  input  1  synchronous flush (e.g. with PC_Reset); empties stack, clears flags
PushAddr  input  AW  address of the call instruction (driven from PC_temp)
RA  output  AW  current top-of-stack; 0 when empty
Count  output  log2(DEPTH)+1  valid entries, 0..DEPTH
Empty  output  1  Count == 0
Full  output  1  Count == DEPTH
Overflow  output  1  sticky: a push occurred while Full
Underflow  output  1  sticky: a pop occurred while Empty

Behaviour:
- Reset (Reset_n low, async): top pointer = 0, Count = 0, Overflow = Underflow = 0. RA = 0, Empty = 1, Full = 0 immediately. Storage contents are don't-care.
- Storage: DEPTH×AW register array written on the Clock rising edge. The top pointer is a log2(DEPTH)-bit wrap-around index of the next free slot.
- RA is combinational from registered state: mem[top-1] when Count > 0, else 0. A push or pop is visible on RA the cycle after the edge (latency 1).
- Stored value = PushAddr + RET_OFFSET, truncated to AW bits (wraps modulo 2^AW).
- Priority: Clear > (Push & Pop) > Push > Pop > idle.
- Push only, not Full: mem[top] <= value, top+1, Count+1.
- Push only, Full: mem[top] <= value, top+1 (overwrites oldest entry), Count stays DEPTH, Overflow <= 1.
- Pop only, not Empty: top-1, Count-1. Storage is untouched.
- Pop only, Empty: no state change except Underflow <= 1. RA stays 0.
- Push & Pop together, Count > 0: replace top in place (mem[top-1] <= value). top and Count are unchanged.
- Push & Pop together, Empty: behaves as Push only (Count becomes 1). No Underflow.
- Clear: top = 0, Count = 0, both sticky flags = 0. Clear overrides Push/Pop in the same cycle.
- Reset asserted mid-operation: state is zeroed immediately regardless of Push/Pop. The first edge after Reset_n deasserts behaves normally.
- Overflow and Underflow stay set until Clear or reset.
- Pointer arithmetic wraps modulo DEPTH. Count never exceeds DEPTH and never goes below 0.

Test Plan:
1. Reset, then push PushAddr=0x10, 0x20, 0x30 on consecutive cycles -> RA = 0x11, 0x21, 0x31 one cycle after each push; Count = 3; Empty = 0.
2. From test 1, pop three times -> RA = 0x21, 0x11, then 0; Count = 0; Empty = 1; Underflow = 0.
3. Pop with the stack empty -> Underflow = 1, Count = 0, RA = 0. Then push 0x40 -> RA = 0x41, Underflow still 1 until Clear.
4. Push 9 addresses 0x1..0x9 with DEPTH = 8 -> Full = 1, Overflow = 1, Count = 8, RA = 0xA. Then 8 pops -> RA sequence 0x9..0x3, then 0; entry 0x2 is lost.
5. Push 0x50, then assert Push & Pop together with PushAddr=0x60 -> Count stays 1, RA = 0x61. Push & Pop on an empty stack with 0x70 -> Count = 1, RA = 0x71.
6. Push two entries, then assert Clear together with Push. Separately, pull Reset_n low between clock edges -> Count = 0, RA = 0, flags = 0. For the reset case, outputs change before the next Clock edge.
